regfile_wb_scheduler: RTL and testbench

Write-port scheduler and pending-write scoreboard in front of the 2-read/1-write register file. Shares the single write port (a3/WD3/WE3) between NUM_REQ writeback sources (ALU, load unit, mul/div) using round-robin valid/ready arbitration. Tracks per-register pending writes so the issue/decode stage can stall on RAW and WAW hazards.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_wb_scheduler_rr_arbiter.sv | 30 +++
 rtl/regfile_wb_scheduler.sv | 99 +++++++++
 tb/tb_regfile_wb_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and writeback source encoding.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    WB_ALU    = 2'd0,
    WB_LOAD   = 2'd1,
    WB_MULDIV = 2'd2
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the pointer wins.
module rr_arbiter #(
  parameter int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  logic [IW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(pointer) + k) % N);
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between writeback sources and tracks
// pending destination registers for RAW/WAW stalls in the issue stage.
module regfile_wb_scheduler #(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = regfile_pkg::REG_ADDR_W,
  parameter int DATA_W   = regfile_pkg::REG_DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_addr,
  input  logic [ADDR_W-1:0]         src1_addr,
  input  logic [ADDR_W-1:0]         src2_addr,
  output logic                      src1_busy,
  output logic                      src2_busy,
  output logic                      dst_busy,
  output logic [ADDR_W-1:0]         rf_a3,
  output logic [DATA_W-1:0]         rf_wd3,
  output logic                      rf_we3,
  output logic [GW-1:0]             grant_id
);
  import regfile_pkg::*;

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [GW-1:0]       ptr_q, ptr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   a3_q, a3_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic [GW-1:0]       gid_q, gid_d;

  logic [GW-1:0]       gnt_idx;
  logic                gnt_any;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .pointer   (ptr_q),
    .grant     (req_ready),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  assign sel_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_data = req_data[gnt_idx*DATA_W +: DATA_W];

  always_comb begin
    ptr_d  = ptr_q;
    we_d   = 1'b0;
    a3_d   = a3_q;
    wd_d   = wd_q;
    gid_d  = gid_q;
    pend_d = pend_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == GW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      we_d  = (sel_addr != ADDR_W'(ZERO_REG));
      a3_d  = sel_addr;
      wd_d  = sel_data;
      gid_d = gnt_idx;
    end
    // Clear first so a same-edge issue to the same register keeps it pending.
    if (we_q) pend_d[a3_q] = 1'b0;
    if (issue_valid && (issue_addr != ADDR_W'(ZERO_REG))) pend_d[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      ptr_q  <= '0;
      we_q   <= 1'b0;
      a3_q   <= '0;
      wd_q   <= '0;
      gid_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      a3_q   <= a3_d;
      wd_q   <= wd_d;
      gid_q  <= gid_d;
    end
  end

  assign src1_busy = pend_q[src1_addr] && (src1_addr != ADDR_W'(ZERO_REG));
  assign src2_busy = pend_q[src2_addr] && (src2_addr != ADDR_W'(ZERO_REG));
  assign dst_busy  = pend_q[issue_addr] && (issue_addr != ADDR_W'(ZERO_REG));

  assign rf_we3   = we_q;
  assign rf_a3    = a3_q;
  assign rf_wd3   = wd_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with a per-cycle reference model.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        issue_valid;
  logic [4:0]  issue_addr, src1_addr, src2_addr;
  logic        src1_busy, src2_busy, dst_busy;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic        rf_we3;
  logic [1:0]  grant_id;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .src1_addr(src1_addr), .src2_addr(src2_addr),
    .src1_busy(src1_busy), .src2_busy(src2_busy), .dst_busy(dst_busy),
    .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3(rf_we3), .grant_id(grant_id)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending set of registers, round-robin pointer, and
  // the write expected on the port in the current cycle.
  bit [31:0]   m_pend;
  int          m_rr;
  bit          m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  int          m_gid;

  always @(negedge clk) begin
    int w;
    logic [4:0] a;
    if (!rst_n) begin
      m_pend = '0; m_rr = 0; m_we = 0; m_a3 = '0; m_wd = '0; m_gid = 0;
      chk("mdl_rst_we3", 32'(rf_we3), 32'd0);
    end else begin
      w = -1;
      for (int k = 0; k < 3; k++)
        if (w < 0 && req_valid[(m_rr + k) % 3]) w = (m_rr + k) % 3;
      chk("mdl_ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
      chk("mdl_src1_busy", 32'(src1_busy), 32'(m_pend[src1_addr] && src1_addr != 0));
      chk("mdl_src2_busy", 32'(src2_busy), 32'(m_pend[src2_addr] && src2_addr != 0));
      chk("mdl_dst_busy", 32'(dst_busy), 32'(m_pend[issue_addr] && issue_addr != 0));
      chk("mdl_we3", 32'(rf_we3), 32'(m_we));
      if (m_we) begin
        chk("mdl_a3", 32'(rf_a3), 32'(m_a3));
        chk("mdl_wd3", rf_wd3, m_wd);
        chk("mdl_gid", 32'(grant_id), 32'(m_gid));
      end
      if (m_we) m_pend[m_a3] = 1'b0;
      if (issue_valid && issue_addr != 0) m_pend[issue_addr] = 1'b1;
      if (w >= 0) begin
        a     = req_addr[w*5 +: 5];
        m_we  = (a != 0);
        m_a3  = a;
        m_wd  = req_data[w*32 +: 32];
        m_gid = w;
        m_rr  = (w + 1) % 3;
      end else begin
        m_we = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]     = v;
    req_addr[i*5 +: 5]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  int seq [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    rst_n = 1'b1;
    req_valid = '0; req_addr = '0; req_data = '0;
    issue_valid = 1'b0; issue_addr = '0; src1_addr = '0; src2_addr = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_we3", 32'(rf_we3), 32'd0);
    chk("rst_a3", 32'(rf_a3), 32'd0);
    chk("rst_wd3", rf_wd3, 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    step(); step();
    rst_n = 1'b1;

    // Three-way contention: rotating grants, back-to-back writes.
    set_req(0, 1'b1, 5'd1, 32'h0000_00A0);
    set_req(1, 1'b1, 5'd2, 32'h0000_00A1);
    set_req(2, 1'b1, 5'd3, 32'h0000_00A2);
    for (int i = 0; i < 6; i++) begin
      #2;
      chk("rr_ready", 32'(req_ready), 32'd1 << seq[i]);
      if (i > 0) begin
        chk("rr_we3", 32'(rf_we3), 32'd1);
        chk("rr_gid", 32'(grant_id), 32'(seq[i-1]));
      end
      step();
    end
    req_valid = '0;
    #2;
    chk("rr_last_we3", 32'(rf_we3), 32'd1);
    chk("rr_last_gid", 32'(grant_id), 32'd2);
    chk("rr_last_a3", 32'(rf_a3), 32'd3);
    chk("rr_last_wd3", rf_wd3, 32'h0000_00A2);
    step();
    #2 chk("rr_idle_we3", 32'(rf_we3), 32'd0);

    // RAW: issue to r5, then requester 1 writes it back.
    step();
    issue_valid = 1'b1; issue_addr = 5'd5;
    step();
    issue_valid = 1'b0; src1_addr = 5'd5;
    set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    #2;
    chk("raw_busy_set", 32'(src1_busy), 32'd1);
    chk("raw_ready", 32'(req_ready), 32'b010);
    step();
    req_valid = '0;
    #2;
    chk("raw_we3", 32'(rf_we3), 32'd1);
    chk("raw_a3", 32'(rf_a3), 32'd5);
    chk("raw_wd3", rf_wd3, 32'hDEAD_BEEF);
    chk("raw_gid", 32'(grant_id), 32'd1);
    chk("raw_busy_inflight", 32'(src1_busy), 32'd1);
    step();
    #2 chk("raw_busy_clr", 32'(src1_busy), 32'd0);

    // Write to r0: handshake only.
    step();
    set_req(0, 1'b1, 5'd0, 32'h0000_1234);
    src1_addr = 5'd0;
    #2 chk("zero_ready", 32'(req_ready), 32'b001);
    step();
    req_valid = '0;
    #2;
    chk("zero_we3", 32'(rf_we3), 32'd0);
    chk("zero_busy", 32'(src1_busy), 32'd0);

    // Same-edge set and clear on r7: the new producer keeps it pending.
    step();
    issue_valid = 1'b1; issue_addr = 5'd7;
    step();
    issue_valid = 1'b0;
    set_req(0, 1'b1, 5'd7, 32'h0000_0077);
    step();
    req_valid = '0;
    issue_valid = 1'b1; issue_addr = 5'd7;
    #2;
    chk("waw_we3", 32'(rf_we3), 32'd1);
    chk("waw_a3", 32'(rf_a3), 32'd7);
    chk("waw_dst_busy", 32'(dst_busy), 32'd1);
    step();
    issue_valid = 1'b0; src2_addr = 5'd7;
    #2 chk("waw_still_pending", 32'(src2_busy), 32'd1);

    // Requester 2 alone moves the pointer to 0, then 0 beats 2.
    step();
    set_req(2, 1'b1, 5'd3, 32'h0000_0333);
    for (int i = 0; i < 3; i++) begin
      #2 chk("solo2_ready", 32'(req_ready), 32'b100);
      step();
    end
    set_req(0, 1'b1, 5'd4, 32'h0000_0444);
    #2 chk("ptr0_ready", 32'(req_ready), 32'b001);
    step();
    #2 chk("ptr1_ready", 32'(req_ready), 32'b100);
    step();
    req_valid = '0;

    // Reset with a write in flight.
    step();
    set_req(1, 1'b1, 5'd9, 32'h0000_0999);
    issue_valid = 1'b1; issue_addr = 5'd9;
    step();
    req_valid = '0; issue_valid = 1'b0;
    src1_addr = 5'd9; src2_addr = 5'd7; issue_addr = 5'd9;
    #1 chk("mid_we3_before", 32'(rf_we3), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_we3_after", 32'(rf_we3), 32'd0);
    chk("mid_src1_busy", 32'(src1_busy), 32'd0);
    chk("mid_src2_busy", 32'(src2_busy), 32'd0);
    chk("mid_dst_busy", 32'(dst_busy), 32'd0);
    step(); step();
    rst_n = 1'b1;
    set_req(0, 1'b1, 5'd1, 32'h0000_0101);
    set_req(1, 1'b1, 5'd2, 32'h0000_0202);
    set_req(2, 1'b1, 5'd3, 32'h0000_0303);
    #2 chk("post_rst_tie", 32'(req_ready), 32'b001);
    step();
    req_valid = '0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
